seven_seg_scan_decoder: RTL

Receive-side counterpart of the multiplexed four-digit seven-segment driver. It samples the active-low segment and anode buses, filters digit dwells for stability and decodes each segment pattern back to a hex nibble. It assembles a complete 16-bit frame once all four digits have been seen, then publishes it with a one-cycle valid pulse. It is used as an in-system loopback checker and on a second board that reads a display bus.

---
 rtl/seven_seg_scan_decoder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
// Receive side of a multiplexed four-digit seven-segment display bus.
// The active-low anode/segment buses are registered. Each digit dwell is
// filtered for stability and decoded back to a hex nibble. Once all four
// digit slots have been captured, the assembled 16-bit frame is published
// with a one-cycle valid pulse.
//
// Handshake: there is no back-pressure. frame_valid_po is a one-cycle
// strobe; num_po and err_po are valid in that cycle and hold until the next
// publish. timeout_po is a one-cycle strobe that marks a discarded partial
// frame and never changes num_po or err_po.

module seven_seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 2,     // 1..255
    parameter int TIMEOUT_CYCLES = 4096   // 2..2^20
) (
    input  logic        clk_pi,
    input  logic        rst_n_pi,
    input  logic [6:0]  seg_pi,
    input  logic [3:0]  an_pi,
    output logic [15:0] num_po,
    output logic        frame_valid_po,
    output logic        err_po,
    output logic        timeout_po
);

    // Timeout counter must be able to hold TIMEOUT_CYCLES-1.
    localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      SETTLE_C  = 8'(SETTLE_CYCLES);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    // Segment pattern -> {error, nibble}. Unknown patterns (including a
    // blank 7F) decode to nibble 0 with the error bit set.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h18:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    // Input stage and one cycle of history for the stability compare.
    logic [3:0]  an_r;
    logic [6:0]  seg_r;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;

    // Dwell filter.
    logic [7:0]  stab_cnt;
    logic [7:0]  stab_next;
    logic        qualified;
    logic [1:0]  dig_idx;
    logic        same_pair;
    logic        capture;
    logic [3:0]  dec_nib;
    logic        dec_err;

    // Frame assembly.
    logic [15:0]   slots;
    logic [15:0]   slots_next;
    logic [3:0]    mask;
    logic [3:0]    mask_next;
    logic [3:0]    err_bits;
    logic [3:0]    err_next;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_next;
    logic          tmo_fire;
    logic          publish;

    // Register the raw buses and keep the previous registered pair.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            an_r  <= 4'hF;
            seg_r <= 7'h7F;
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
        end else begin
            an_r  <= an_pi;
            seg_r <= seg_pi;
            an_q  <= an_r;
            seg_q <= seg_r;
        end
    end

    // Only a single low anode selects a digit; anything else is ignored.
    always_comb begin
        qualified = 1'b1;
        dig_idx   = 2'd0;
        case (an_r)
            4'b1110: dig_idx = 2'd0;
            4'b1101: dig_idx = 2'd1;
            4'b1011: dig_idx = 2'd2;
            4'b0111: dig_idx = 2'd3;
            default: qualified = 1'b0;
        endcase
    end

    // Stability count: saturating run length of an unchanged qualified pair.
    // A capture fires only on the cycle the count reaches SETTLE_CYCLES, so
    // one dwell yields exactly one capture.
    always_comb begin
        same_pair = (an_r == an_q) && (seg_r == seg_q);
        stab_next = 8'd0;
        if (qualified) begin
            if (same_pair)
                stab_next = (stab_cnt == 8'hFF) ? stab_cnt : stab_cnt + 8'd1;
            else
                stab_next = 8'd1;
        end
        capture = qualified && (stab_next == SETTLE_C) &&
                  !(same_pair && (stab_cnt == SETTLE_C));
        {dec_err, dec_nib} = decode_seg(seg_r);
    end

    // Stability counter register.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi)
            stab_cnt <= 8'd0;
        else
            stab_cnt <= stab_next;
    end

    // Frame assembly next state: publish clears the mask, a coincident
    // capture then seeds the next frame, otherwise the timeout runs while a
    // partial frame is pending.
    always_comb begin
        publish    = (mask == 4'hF);
        slots_next = slots;
        mask_next  = mask;
        err_next   = err_bits;
        tmo_next   = tmo_cnt;
        tmo_fire   = 1'b0;

        if (publish) begin
            mask_next = 4'h0;
            err_next  = 4'h0;
        end

        if (capture) begin
            mask_next[dig_idx]               = 1'b1;
            err_next[dig_idx]                = dec_err;
            slots_next[{dig_idx, 2'b00} +: 4] = dec_nib;
            tmo_next                         = '0;
        end else if ((mask != 4'h0) && !publish) begin
            if (tmo_cnt == TMO_LAST) begin
                tmo_fire  = 1'b1;
                mask_next = 4'h0;
                err_next  = 4'h0;
                tmo_next  = '0;
            end else begin
                tmo_next = tmo_cnt + 1'b1;
            end
        end else begin
            tmo_next = '0;
        end
    end

    // Frame assembly state registers.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            slots    <= 16'h0000;
            mask     <= 4'h0;
            err_bits <= 4'h0;
            tmo_cnt  <= '0;
        end else begin
            slots    <= slots_next;
            mask     <= mask_next;
            err_bits <= err_next;
            tmo_cnt  <= tmo_next;
        end
    end

    // Published outputs; num_po/err_po hold between publishes.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            num_po         <= 16'h0000;
            err_po         <= 1'b0;
            frame_valid_po <= 1'b0;
            timeout_po     <= 1'b0;
        end else begin
            frame_valid_po <= publish;
            timeout_po     <= tmo_fire;
            if (publish) begin
                num_po <= slots;
                err_po <= |err_bits;
            end
        end
    end

endmodule
